// File: rtl/i2c_master_arbiter.sv
// Round-robin scheduler that shares one I2C master controller between NUM_REQ requesters.
// Latches the winner's descriptor, counts byte strobes, and enforces a bus-free gap between owners.
module i2c_master_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 40,
  parameter int GAP_CYC     = 4
) (
  input  logic                     i2c_clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*8-1:0]     i_req_addr,
  input  logic [NUM_REQ*LEN_W-1:0] i_req_len,
  input  logic                     i_byte_done,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_err,
  output logic                     o_ctl_enable,
  output logic [7:0]               o_ctl_slave_address,
  output logic                     o_busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_XFER,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t               r_state,     w_state_nxt;
  logic [IW-1:0]        r_last,      w_last_nxt;
  logic [NUM_REQ-1:0]   r_grant,     w_grant_nxt;
  logic [NUM_REQ-1:0]   r_done,      w_done_nxt;
  logic                 r_err,       w_err_nxt;
  logic                 r_err_flag,  w_err_flag_nxt;
  logic                 r_enable,    w_enable_nxt;
  logic [7:0]           r_addr,      w_addr_nxt;
  logic                 r_busy,      w_busy_nxt;
  logic [LEN_W-1:0]     r_byte_cnt,  w_byte_cnt_nxt;
  logic [TW-1:0]        r_tmo_cnt,   w_tmo_cnt_nxt;
  logic [GW-1:0]        r_gap_cnt,   w_gap_cnt_nxt;

  logic                 w_found;
  logic [IW-1:0]        w_winner;
  logic [IW-1:0]        w_idx;
  logic [NUM_REQ-1:0]   w_win_onehot;
  logic [7:0]           w_win_addr;
  logic [LEN_W-1:0]     w_win_len;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last;
    w_idx    = r_last;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (w_idx == LAST_REQ) ? '0 : w_idx + IW'(1);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end

    w_win_onehot = '0;
    w_win_addr   = '0;
    w_win_len    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IW'(i)) begin
        w_win_onehot[i] = 1'b1;
        w_win_addr      = i_req_addr[8*i +: 8];
        w_win_len       = i_req_len[LEN_W*i +: LEN_W];
      end
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_grant_nxt    = r_grant;
    w_err_flag_nxt = r_err_flag;
    w_enable_nxt   = r_enable;
    w_addr_nxt     = r_addr;
    w_byte_cnt_nxt = r_byte_cnt;
    w_tmo_cnt_nxt  = r_tmo_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;

    case (r_state)
      ST_IDLE: begin
        if (|i_req_valid) w_state_nxt = ST_ARB;
      end

      ST_ARB: begin
        if (w_found) begin
          w_grant_nxt    = w_win_onehot;
          w_last_nxt     = w_winner;
          w_addr_nxt     = w_win_addr;
          w_byte_cnt_nxt = w_win_len;
          w_tmo_cnt_nxt  = '0;
          if (w_win_len == '0) begin
            w_err_flag_nxt = 1'b1;
            w_state_nxt    = ST_DONE;
          end else begin
            w_err_flag_nxt = 1'b0;
            w_enable_nxt   = 1'b1;
            w_state_nxt    = ST_XFER;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_XFER: begin
        // A strobe in the timeout cycle counts as progress and wins over the abort.
        if (i_byte_done && (r_byte_cnt != '0)) begin
          w_byte_cnt_nxt = r_byte_cnt - LEN_W'(1);
          w_tmo_cnt_nxt  = '0;
          if (r_byte_cnt == LEN_W'(1)) begin
            w_enable_nxt   = 1'b0;
            w_err_flag_nxt = 1'b0;
            w_gap_cnt_nxt  = '0;
            w_state_nxt    = ST_DRAIN;
          end
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_enable_nxt   = 1'b0;
          w_err_flag_nxt = 1'b1;
          w_gap_cnt_nxt  = '0;
          w_state_nxt    = ST_DRAIN;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
        end
      end

      ST_DRAIN: begin
        if (r_gap_cnt == GAP_LAST) w_state_nxt = ST_DONE;
        else                       w_gap_cnt_nxt = r_gap_cnt + GW'(1);
      end

      ST_DONE: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // Status outputs are decoded from the next state so they leave registers aligned with it.
    w_done_nxt = (w_state_nxt == ST_DONE) ? w_grant_nxt : '0;
    w_err_nxt  = (w_state_nxt == ST_DONE) ? w_err_flag_nxt : 1'b0;
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge i2c_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last     <= LAST_REQ;
      r_grant    <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_err_flag <= 1'b0;
      r_enable   <= 1'b0;
      r_addr     <= 8'h00;
      r_busy     <= 1'b0;
      r_byte_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_err_flag <= w_err_flag_nxt;
      r_enable   <= w_enable_nxt;
      r_addr     <= w_addr_nxt;
      r_busy     <= w_busy_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
    end
  end

  assign o_grant             = r_grant;
  assign o_done              = r_done;
  assign o_err               = r_err;
  assign o_ctl_enable        = r_enable;
  assign o_ctl_slave_address = r_addr;
  assign o_busy              = r_busy;

endmodule
